// File: rtl/midgard_mmu.sv
// Midgard-to-physical cache-line translation between the LLC and memory.
// Segment registers are checked first; a miss walks a single-level page table through the LLC.
module midgard_mmu #(
  parameter int MCN_W  = 58,
  parameter int PCN_W  = 42,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              llc_req_i_valid,
  output logic              llc_req_i_ready,
  input  logic [IDX_W-1:0]  llc_req_i_bits_idx,
  input  logic              llc_req_i_bits_rnw,
  input  logic [MCN_W-1:0]  llc_req_i_bits_mcn,
  input  logic [PCN_W-1:0]  llc_req_i_bits_pcn,
  input  logic [DATA_W-1:0] llc_req_i_bits_data,
  output logic              llc_resp_o_valid,
  input  logic              llc_resp_o_ready,
  output logic [IDX_W-1:0]  llc_resp_o_bits_idx,
  output logic              llc_resp_o_bits_err,
  output logic              llc_resp_o_bits_rnw,
  output logic [DATA_W-1:0] llc_resp_o_bits_data,
  output logic              llc_req_o_valid,
  input  logic              llc_req_o_ready,
  output logic [MCN_W-1:0]  llc_req_o_bits_mcn,
  input  logic              llc_resp_i_valid,
  output logic              llc_resp_i_ready,
  input  logic              llc_resp_i_bits_hit,
  input  logic [DATA_W-1:0] llc_resp_i_bits_data,
  output logic              mem_req_o_valid,
  input  logic              mem_req_o_ready,
  output logic [IDX_W-1:0]  mem_req_o_bits_idx,
  output logic              mem_req_o_bits_rnw,
  output logic [MCN_W-1:0]  mem_req_o_bits_mcn,
  output logic [PCN_W-1:0]  mem_req_o_bits_pcn,
  output logic [DATA_W-1:0] mem_req_o_bits_data,
  input  logic              mem_resp_i_valid,
  output logic              mem_resp_i_ready,
  input  logic [IDX_W-1:0]  mem_resp_i_bits_idx,
  input  logic              mem_resp_i_bits_err,
  input  logic              mem_resp_i_bits_rnw,
  input  logic [DATA_W-1:0] mem_resp_i_bits_data,
  input  logic              ctl_req_i_valid,
  output logic              ctl_req_i_ready,
  input  logic              ctl_req_i_bits_rnw,
  input  logic [63:0]       ctl_req_i_bits_addr,
  input  logic [63:0]       ctl_req_i_bits_data,
  output logic              ctl_resp_o_valid,
  input  logic              ctl_resp_o_ready,
  output logic              ctl_resp_o_bits_sel,
  output logic              ctl_resp_o_bits_rnw,
  output logic [63:0]       ctl_resp_o_bits_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_XLAT, S_MEM, S_PTW_REQ, S_PTW_RESP, S_FAULT
  } state_t;

  localparam int PAD_W = 64 - MCN_W;

  state_t             state_r, state_s;
  logic [63:0]        ctl_r, ptb_r, fault_mcn_r;
  logic [63:0]        seg_base_r [0:3];
  logic [63:0]        seg_limit_r [0:3];
  logic [63:0]        seg_offs_r [0:3];
  logic [63:0]        seg_attr_r [0:3];
  logic [31:0]        fault_cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic               rnw_r, run_r, fault_hold_r;
  logic [MCN_W-1:0]   mcn_r, probe_r, probe_s;
  logic [PCN_W-1:0]   pcn_r, pcn_s;
  logic [DATA_W-1:0]  data_r;
  logic               ctl_valid_r, ctl_sel_r, ctl_rnw_r;
  logic [63:0]        ctl_data_r;

  logic [63:0]        mcn64_s, pte_s, rd_data_s;
  logic [MCN_W-1:0]   seg_sum_s [0:3];
  logic [3:0]         seg_match_s;
  logic               seg_hit_s, seg_w_s, fault_drv_s, fault_fire_s;
  logic               ctl_acc_s, mapped_s, seg_rng_s;
  logic [PCN_W-1:0]   seg_pcn_s;
  logic [4:0]         word_s, seg_word_s;
  logic [1:0]         seg_sel_s, fld_s;
  logic               unused_s;

  assign mcn64_s = {{PAD_W{1'b0}}, mcn_r};
  assign probe_s = ptb_r[MCN_W-1:0] + (mcn_r >> 3);
  assign pte_s   = llc_resp_i_bits_data[{mcn_r[2:0], 6'b000000} +: 64];

  // Per-segment range match and translated line number.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      seg_match_s[i] = seg_attr_r[i][0] && (mcn64_s >= seg_base_r[i]) && (mcn64_s <= seg_limit_r[i]);
      seg_sum_s[i]   = mcn_r + seg_offs_r[i][MCN_W-1:0];
    end
  end

  // Lowest-numbered matching segment wins.
  always_comb begin
    seg_hit_s = 1'b1;
    seg_w_s   = 1'b0;
    seg_pcn_s = '0;
    casez (seg_match_s)
      4'b???1: begin seg_w_s = seg_attr_r[0][1]; seg_pcn_s = seg_sum_s[0][PCN_W-1:0]; end
      4'b??10: begin seg_w_s = seg_attr_r[1][1]; seg_pcn_s = seg_sum_s[1][PCN_W-1:0]; end
      4'b?100: begin seg_w_s = seg_attr_r[2][1]; seg_pcn_s = seg_sum_s[2][PCN_W-1:0]; end
      4'b1000: begin seg_w_s = seg_attr_r[3][1]; seg_pcn_s = seg_sum_s[3][PCN_W-1:0]; end
      default: seg_hit_s = 1'b0;
    endcase
  end

  // Translation FSM next state and translated PCN.
  always_comb begin
    state_s = state_r;
    pcn_s   = pcn_r;
    case (state_r)
      S_IDLE: begin
        if (llc_req_i_valid) state_s = S_XLAT;
        else                 state_s = S_IDLE;
      end
      S_XLAT: begin
        if (!ctl_r[0]) begin
          state_s = S_MEM;
          pcn_s   = mcn_r[PCN_W-1:0];
        end else if (seg_hit_s) begin
          if (!rnw_r && !seg_w_s) begin
            state_s = S_FAULT;
          end else begin
            state_s = S_MEM;
            pcn_s   = seg_pcn_s;
          end
        end else begin
          state_s = S_PTW_REQ;
        end
      end
      S_PTW_REQ: begin
        if (llc_req_o_ready) state_s = S_PTW_RESP;
        else                 state_s = S_PTW_REQ;
      end
      S_PTW_RESP: begin
        if (!llc_resp_i_valid) begin
          state_s = S_PTW_RESP;
        end else if (!llc_resp_i_bits_hit || !pte_s[0] || (!rnw_r && !pte_s[1])) begin
          state_s = S_FAULT;
        end else begin
          state_s = S_MEM;
          pcn_s   = pte_s[PCN_W+9:10];
        end
      end
      S_MEM: begin
        if (mem_req_o_ready) state_s = S_IDLE;
        else                 state_s = S_MEM;
      end
      S_FAULT: begin
        if (fault_fire_s) state_s = S_IDLE;
        else              state_s = S_FAULT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state, captured request and walk probe address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      rnw_r   <= 1'b0;
      mcn_r   <= '0;
      data_r  <= '0;
      pcn_r   <= '0;
      probe_r <= '0;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pcn_r   <= pcn_s;
      run_r   <= 1'b1;
      if (state_r == S_IDLE && llc_req_i_valid) begin
        idx_r  <= llc_req_i_bits_idx;
        rnw_r  <= llc_req_i_bits_rnw;
        mcn_r  <= llc_req_i_bits_mcn;
        data_r <= llc_req_i_bits_data;
      end
      if (state_r == S_XLAT) probe_r <= probe_s;
    end
  end

  // A fault response waits behind a pending memory response, then holds until taken.
  assign fault_drv_s  = (state_r == S_FAULT) && (fault_hold_r || !mem_resp_i_valid);
  assign fault_fire_s = fault_drv_s && llc_resp_o_ready;

  // Fault response hold flag and fault statistics.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_hold_r <= 1'b0;
      fault_cnt_r  <= 32'd0;
      fault_mcn_r  <= 64'd0;
    end else begin
      if (fault_fire_s) begin
        fault_hold_r <= 1'b0;
        fault_mcn_r  <= mcn64_s;
        if (fault_cnt_r != 32'hFFFF_FFFF) fault_cnt_r <= fault_cnt_r + 32'd1;
      end else if (fault_drv_s) begin
        fault_hold_r <= 1'b1;
      end
    end
  end

  // LLC response mux: memory pass-through or locally generated fault.
  always_comb begin
    llc_resp_o_valid     = 1'b0;
    llc_resp_o_bits_idx  = '0;
    llc_resp_o_bits_err  = 1'b0;
    llc_resp_o_bits_rnw  = 1'b0;
    llc_resp_o_bits_data = '0;
    if (run_r && fault_drv_s) begin
      llc_resp_o_valid     = 1'b1;
      llc_resp_o_bits_idx  = idx_r;
      llc_resp_o_bits_err  = 1'b1;
      llc_resp_o_bits_rnw  = rnw_r;
    end else if (run_r) begin
      llc_resp_o_valid     = mem_resp_i_valid;
      llc_resp_o_bits_idx  = mem_resp_i_bits_idx;
      llc_resp_o_bits_err  = mem_resp_i_bits_err;
      llc_resp_o_bits_rnw  = mem_resp_i_bits_rnw;
      llc_resp_o_bits_data = mem_resp_i_bits_data;
    end else begin
      llc_resp_o_valid     = 1'b0;
    end
  end

  assign mem_resp_i_ready    = run_r && !fault_drv_s && llc_resp_o_ready;
  assign llc_req_i_ready     = (state_r == S_IDLE);
  assign llc_req_o_valid     = (state_r == S_PTW_REQ);
  assign llc_req_o_bits_mcn  = probe_r;
  assign llc_resp_i_ready    = (state_r == S_PTW_RESP);
  assign mem_req_o_valid     = (state_r == S_MEM);
  assign mem_req_o_bits_idx  = idx_r;
  assign mem_req_o_bits_rnw  = rnw_r;
  assign mem_req_o_bits_mcn  = mcn_r;
  assign mem_req_o_bits_pcn  = pcn_r;
  assign mem_req_o_bits_data = data_r;

  // Register map: word 0 CTL, 1 PTB, 2..17 segment quads, 18 FAULT_CNT, 19 FAULT_MCN.
  assign ctl_acc_s  = ctl_req_i_valid && !ctl_valid_r;
  assign word_s     = ctl_req_i_bits_addr[7:3];
  assign mapped_s   = (ctl_req_i_bits_addr[63:8] == 56'd0) && (word_s < 5'd20);
  assign seg_word_s = word_s - 5'd2;
  assign seg_sel_s  = seg_word_s[3:2];
  assign fld_s      = seg_word_s[1:0];
  assign seg_rng_s  = (word_s >= 5'd2) && (word_s <= 5'd17);

  // Control-port read data.
  always_comb begin
    rd_data_s = 64'd0;
    if (!mapped_s) begin
      rd_data_s = 64'd0;
    end else if (seg_rng_s) begin
      case (fld_s)
        2'd0:    rd_data_s = seg_base_r[seg_sel_s];
        2'd1:    rd_data_s = seg_limit_r[seg_sel_s];
        2'd2:    rd_data_s = seg_offs_r[seg_sel_s];
        default: rd_data_s = seg_attr_r[seg_sel_s];
      endcase
    end else begin
      case (word_s)
        5'd0:    rd_data_s = ctl_r;
        5'd1:    rd_data_s = ptb_r;
        5'd18:   rd_data_s = {32'd0, fault_cnt_r};
        default: rd_data_s = fault_mcn_r;
      endcase
    end
  end

  // Control-port register writes and registered response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctl_r       <= 64'd0;
      ptb_r       <= 64'd0;
      ctl_valid_r <= 1'b0;
      ctl_sel_r   <= 1'b0;
      ctl_rnw_r   <= 1'b0;
      ctl_data_r  <= 64'd0;
      for (int i = 0; i < 4; i++) begin
        seg_base_r[i]  <= 64'd0;
        seg_limit_r[i] <= 64'd0;
        seg_offs_r[i]  <= 64'd0;
        seg_attr_r[i]  <= 64'd0;
      end
    end else begin
      if (ctl_acc_s) begin
        ctl_valid_r <= 1'b1;
        ctl_sel_r   <= mapped_s;
        ctl_rnw_r   <= ctl_req_i_bits_rnw;
        ctl_data_r  <= ctl_req_i_bits_rnw ? rd_data_s : 64'd0;
      end else if (ctl_resp_o_ready) begin
        ctl_valid_r <= 1'b0;
      end
      if (ctl_acc_s && !ctl_req_i_bits_rnw && mapped_s) begin
        if (seg_rng_s) begin
          case (fld_s)
            2'd0:    seg_base_r[seg_sel_s]  <= ctl_req_i_bits_data;
            2'd1:    seg_limit_r[seg_sel_s] <= ctl_req_i_bits_data;
            2'd2:    seg_offs_r[seg_sel_s]  <= ctl_req_i_bits_data;
            default: seg_attr_r[seg_sel_s]  <= ctl_req_i_bits_data;
          endcase
        end else if (word_s == 5'd0) begin
          ctl_r <= ctl_req_i_bits_data;
        end else if (word_s == 5'd1) begin
          ptb_r <= ctl_req_i_bits_data;
        end
      end
    end
  end

  assign ctl_req_i_ready      = !ctl_valid_r;
  assign ctl_resp_o_valid     = ctl_valid_r;
  assign ctl_resp_o_bits_sel  = ctl_sel_r;
  assign ctl_resp_o_bits_rnw  = ctl_rnw_r;
  assign ctl_resp_o_bits_data = ctl_data_r;

  assign unused_s = ^{llc_req_i_bits_pcn, ctl_req_i_bits_addr[2:0], pte_s};

endmodule

// File: tb/tb_midgard_mmu.sv
// Directed self-checking bench for midgard_mmu: bypass, segment, walk, fault,
// backpressure, response priority and register-map behaviour.
module tb_midgard_mmu;
  localparam int MCN_W = 58, PCN_W = 42, IDX_W = 4, DATA_W = 512;

  logic clock = 1'b0, reset = 1'b0;
  logic llc_req_i_valid, llc_req_i_ready, llc_req_i_bits_rnw;
  logic [IDX_W-1:0] llc_req_i_bits_idx;
  logic [MCN_W-1:0] llc_req_i_bits_mcn;
  logic [PCN_W-1:0] llc_req_i_bits_pcn;
  logic [DATA_W-1:0] llc_req_i_bits_data;
  logic llc_resp_o_valid, llc_resp_o_ready, llc_resp_o_bits_err, llc_resp_o_bits_rnw;
  logic [IDX_W-1:0] llc_resp_o_bits_idx;
  logic [DATA_W-1:0] llc_resp_o_bits_data;
  logic llc_req_o_valid, llc_req_o_ready;
  logic [MCN_W-1:0] llc_req_o_bits_mcn;
  logic llc_resp_i_valid, llc_resp_i_ready, llc_resp_i_bits_hit;
  logic [DATA_W-1:0] llc_resp_i_bits_data;
  logic mem_req_o_valid, mem_req_o_ready, mem_req_o_bits_rnw;
  logic [IDX_W-1:0] mem_req_o_bits_idx;
  logic [MCN_W-1:0] mem_req_o_bits_mcn;
  logic [PCN_W-1:0] mem_req_o_bits_pcn;
  logic [DATA_W-1:0] mem_req_o_bits_data;
  logic mem_resp_i_valid, mem_resp_i_ready, mem_resp_i_bits_err, mem_resp_i_bits_rnw;
  logic [IDX_W-1:0] mem_resp_i_bits_idx;
  logic [DATA_W-1:0] mem_resp_i_bits_data;
  logic ctl_req_i_valid, ctl_req_i_ready, ctl_req_i_bits_rnw;
  logic [63:0] ctl_req_i_bits_addr, ctl_req_i_bits_data;
  logic ctl_resp_o_valid, ctl_resp_o_ready, ctl_resp_o_bits_sel, ctl_resp_o_bits_rnw;
  logic [63:0] ctl_resp_o_bits_data;

  int checks = 0, errors = 0;

  midgard_mmu #(.MCN_W(MCN_W), .PCN_W(PCN_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .llc_req_i_valid(llc_req_i_valid), .llc_req_i_ready(llc_req_i_ready),
    .llc_req_i_bits_idx(llc_req_i_bits_idx), .llc_req_i_bits_rnw(llc_req_i_bits_rnw),
    .llc_req_i_bits_mcn(llc_req_i_bits_mcn), .llc_req_i_bits_pcn(llc_req_i_bits_pcn),
    .llc_req_i_bits_data(llc_req_i_bits_data),
    .llc_resp_o_valid(llc_resp_o_valid), .llc_resp_o_ready(llc_resp_o_ready),
    .llc_resp_o_bits_idx(llc_resp_o_bits_idx), .llc_resp_o_bits_err(llc_resp_o_bits_err),
    .llc_resp_o_bits_rnw(llc_resp_o_bits_rnw), .llc_resp_o_bits_data(llc_resp_o_bits_data),
    .llc_req_o_valid(llc_req_o_valid), .llc_req_o_ready(llc_req_o_ready),
    .llc_req_o_bits_mcn(llc_req_o_bits_mcn),
    .llc_resp_i_valid(llc_resp_i_valid), .llc_resp_i_ready(llc_resp_i_ready),
    .llc_resp_i_bits_hit(llc_resp_i_bits_hit), .llc_resp_i_bits_data(llc_resp_i_bits_data),
    .mem_req_o_valid(mem_req_o_valid), .mem_req_o_ready(mem_req_o_ready),
    .mem_req_o_bits_idx(mem_req_o_bits_idx), .mem_req_o_bits_rnw(mem_req_o_bits_rnw),
    .mem_req_o_bits_mcn(mem_req_o_bits_mcn), .mem_req_o_bits_pcn(mem_req_o_bits_pcn),
    .mem_req_o_bits_data(mem_req_o_bits_data),
    .mem_resp_i_valid(mem_resp_i_valid), .mem_resp_i_ready(mem_resp_i_ready),
    .mem_resp_i_bits_idx(mem_resp_i_bits_idx), .mem_resp_i_bits_err(mem_resp_i_bits_err),
    .mem_resp_i_bits_rnw(mem_resp_i_bits_rnw), .mem_resp_i_bits_data(mem_resp_i_bits_data),
    .ctl_req_i_valid(ctl_req_i_valid), .ctl_req_i_ready(ctl_req_i_ready),
    .ctl_req_i_bits_rnw(ctl_req_i_bits_rnw), .ctl_req_i_bits_addr(ctl_req_i_bits_addr),
    .ctl_req_i_bits_data(ctl_req_i_bits_data),
    .ctl_resp_o_valid(ctl_resp_o_valid), .ctl_resp_o_ready(ctl_resp_o_ready),
    .ctl_resp_o_bits_sel(ctl_resp_o_bits_sel), .ctl_resp_o_bits_rnw(ctl_resp_o_bits_rnw),
    .ctl_resp_o_bits_data(ctl_resp_o_bits_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl_acc(input logic rnw, input logic [63:0] a, input logic [63:0] d,
                         output logic sel, output logic [63:0] rd);
    ctl_req_i_valid = 1'b1; ctl_req_i_bits_rnw = rnw;
    ctl_req_i_bits_addr = a; ctl_req_i_bits_data = d;
    tick();
    ctl_req_i_valid = 1'b0;
    chk("ctl_resp_valid", {63'd0, ctl_resp_o_valid}, 64'd1);
    sel = ctl_resp_o_bits_sel;
    rd  = ctl_resp_o_bits_data;
    tick();
  endtask

  task automatic ctl_wr(input logic [63:0] a, input logic [63:0] d);
    logic s;
    logic [63:0] r;
    ctl_acc(1'b0, a, d, s, r);
  endtask

  task automatic send_req(input logic rnw, input logic [MCN_W-1:0] m, input logic [IDX_W-1:0] i,
                          input logic [DATA_W-1:0] d);
    int n = 0;
    while (!llc_req_i_ready && n < 50) begin tick(); n++; end
    chk("req_ready_timeout", {63'd0, llc_req_i_ready}, 64'd1);
    llc_req_i_valid = 1'b1; llc_req_i_bits_rnw = rnw;
    llc_req_i_bits_mcn = m; llc_req_i_bits_idx = i; llc_req_i_bits_data = d;
    tick();
    llc_req_i_valid = 1'b0;
  endtask

  // Returns cycles from the request handshake cycle to mem_req_o_valid.
  task automatic wait_mem(output int lat);
    int n = 0;
    while (!mem_req_o_valid && n < 50) begin tick(); n++; end
    chk("mem_valid_timeout", {63'd0, mem_req_o_valid}, 64'd1);
    lat = n + 1;
  endtask

  task automatic wait_probe();
    int n = 0;
    while (!llc_req_o_valid && n < 50) begin tick(); n++; end
    chk("probe_timeout", {63'd0, llc_req_o_valid}, 64'd1);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!llc_resp_o_valid && n < 50) begin tick(); n++; end
    chk("resp_timeout", {63'd0, llc_resp_o_valid}, 64'd1);
  endtask

  task automatic ptw(input logic hit, input logic [DATA_W-1:0] d);
    llc_req_o_ready = 1'b1;
    tick();
    llc_req_o_ready = 1'b0;
    chk("llc_resp_i_ready", {63'd0, llc_resp_i_ready}, 64'd1);
    llc_resp_i_valid = 1'b1; llc_resp_i_bits_hit = hit; llc_resp_i_bits_data = d;
    tick();
    llc_resp_i_valid = 1'b0;
  endtask

  task automatic mem_accept();
    mem_req_o_ready = 1'b1;
    tick();
    mem_req_o_ready = 1'b0;
  endtask

  task automatic resp_accept();
    llc_resp_o_ready = 1'b1;
    tick();
    llc_resp_o_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic s;
    logic [63:0] rd;
    logic [DATA_W-1:0] d;
    logic [PCN_W-1:0] pcn0;

    llc_req_i_valid = 1'b0; llc_req_i_bits_idx = '0; llc_req_i_bits_rnw = 1'b0;
    llc_req_i_bits_mcn = '0; llc_req_i_bits_pcn = '0; llc_req_i_bits_data = '0;
    llc_resp_o_ready = 1'b0; llc_req_o_ready = 1'b0;
    llc_resp_i_valid = 1'b0; llc_resp_i_bits_hit = 1'b0; llc_resp_i_bits_data = '0;
    mem_req_o_ready = 1'b0;
    mem_resp_i_valid = 1'b1; mem_resp_i_bits_idx = 4'd1; mem_resp_i_bits_err = 1'b0;
    mem_resp_i_bits_rnw = 1'b1; mem_resp_i_bits_data = '0;
    ctl_req_i_valid = 1'b0; ctl_req_i_bits_rnw = 1'b0;
    ctl_req_i_bits_addr = 64'd0; ctl_req_i_bits_data = 64'd0;
    ctl_resp_o_ready = 1'b1;

    // Reset: valid outputs low even with a memory response presented.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_llc_resp_valid", {63'd0, llc_resp_o_valid}, 64'd0);
    chk("rst_mem_req_valid", {63'd0, mem_req_o_valid}, 64'd0);
    chk("rst_probe_valid", {63'd0, llc_req_o_valid}, 64'd0);
    chk("rst_ctl_resp_valid", {63'd0, ctl_resp_o_valid}, 64'd0);
    chk("rst_mem_pcn", {22'd0, mem_req_o_bits_pcn}, 64'd0);
    mem_resp_i_valid = 1'b0;
    reset = 1'b1;
    tick();
    ctl_acc(1'b1, 64'h00, 64'd0, s, rd);
    chk("rst_ctl_reg", rd, 64'd0);

    // EN=0 bypass: PCN is the low PCN_W bits of the MCN.
    d = '0; d[63:0] = 64'h1122_3344_5566_7788; d[511:448] = 64'hCAFE_F00D_0000_0001;
    send_req(1'b1, 58'h400_0000_0123, 4'd3, d);
    wait_mem(lat);
    chk("bypass_lat", lat, 64'd2);
    chk("bypass_pcn", {22'd0, mem_req_o_bits_pcn}, 64'h123);
    chk("bypass_mcn", {6'd0, mem_req_o_bits_mcn}, 64'h400_0000_0123);
    chk("bypass_idx", {60'd0, mem_req_o_bits_idx}, 64'd3);
    mem_accept();

    // Memory response passes through unmodified.
    mem_resp_i_valid = 1'b1; mem_resp_i_bits_idx = 4'd5; mem_resp_i_bits_err = 1'b0;
    mem_resp_i_bits_rnw = 1'b1; mem_resp_i_bits_data = d;
    #1;
    chk("memresp_valid", {63'd0, llc_resp_o_valid}, 64'd1);
    chk("memresp_idx", {60'd0, llc_resp_o_bits_idx}, 64'd5);
    chk("memresp_err", {63'd0, llc_resp_o_bits_err}, 64'd0);
    chk("memresp_data_hi", llc_resp_o_bits_data[511:448], 64'hCAFE_F00D_0000_0001);
    chk("memresp_ready_bp", {63'd0, mem_resp_i_ready}, 64'd0);
    llc_resp_o_ready = 1'b1;
    #1;
    chk("memresp_ready", {63'd0, mem_resp_i_ready}, 64'd1);
    tick();
    mem_resp_i_valid = 1'b0; llc_resp_o_ready = 1'b0;

    // Segment 0 hit and segment miss that walks from PTB=0.
    ctl_wr(64'h10, 64'h1000); ctl_wr(64'h18, 64'h1FFF);
    ctl_wr(64'h20, 64'h10);   ctl_wr(64'h28, 64'h3);
    ctl_wr(64'h00, 64'h1);
    send_req(1'b1, 58'h1800, 4'd2, '0);
    wait_mem(lat);
    chk("seg0_lat", lat, 64'd2);
    chk("seg0_pcn", {22'd0, mem_req_o_bits_pcn}, 64'h1810);
    mem_accept();
    send_req(1'b0, 58'h2000, 4'd4, d);
    wait_probe();
    chk("miss_probe_mcn", {6'd0, llc_req_o_bits_mcn}, 64'h400);
    d = '0; d[63:0] = (64'h77 << 10) | 64'h3;
    ptw(1'b1, d);
    wait_mem(lat);
    chk("miss_pcn", {22'd0, mem_req_o_bits_pcn}, 64'h77);
    chk("miss_data_lo", mem_req_o_bits_data[63:0], 64'h1122_3344_5566_7788);
    chk("miss_rnw", {63'd0, mem_req_o_bits_rnw}, 64'd0);
    mem_accept();

    // Segment 1 read-only: write faults with no memory request.
    ctl_wr(64'h30, 64'h3000); ctl_wr(64'h38, 64'h3FFF);
    ctl_wr(64'h40, 64'h0);    ctl_wr(64'h48, 64'h1);
    send_req(1'b0, 58'h3456, 4'd6, '1);
    wait_resp();
    chk("segflt_err", {63'd0, llc_resp_o_bits_err}, 64'd1);
    chk("segflt_idx", {60'd0, llc_resp_o_bits_idx}, 64'd6);
    chk("segflt_rnw", {63'd0, llc_resp_o_bits_rnw}, 64'd0);
    chk("segflt_data", llc_resp_o_bits_data[63:0], 64'd0);
    chk("segflt_no_mem", {63'd0, mem_req_o_valid}, 64'd0);
    resp_accept();
    ctl_acc(1'b1, 64'h90, 64'd0, s, rd);
    chk("fault_cnt_1", rd, 64'd1);
    ctl_acc(1'b1, 64'h98, 64'd0, s, rd);
    chk("fault_mcn_1", rd, 64'h3456);

    // Page-table walk with PTB=0x100: hit, then LLC miss.
    ctl_wr(64'h08, 64'h100);
    send_req(1'b1, 58'h0A, 4'd8, '0);
    wait_probe();
    chk("walk_probe_mcn", {6'd0, llc_req_o_bits_mcn}, 64'h101);
    d = '0; d[2*64 +: 64] = (64'h55 << 10) | 64'h3;
    ptw(1'b1, d);
    wait_mem(lat);
    chk("walk_pcn", {22'd0, mem_req_o_bits_pcn}, 64'h55);
    mem_accept();
    send_req(1'b1, 58'h0A, 4'd10, '0);
    wait_probe();
    ptw(1'b0, d);
    wait_resp();
    chk("walkmiss_err", {63'd0, llc_resp_o_bits_err}, 64'd1);
    chk("walkmiss_idx", {60'd0, llc_resp_o_bits_idx}, 64'd10);
    resp_accept();

    // Backpressure on mem_req_o: payload and valid hold, no new request accepted.
    send_req(1'b1, 58'h1800, 4'd11, '0);
    wait_mem(lat);
    pcn0 = mem_req_o_bits_pcn;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req_o_valid && mem_req_o_bits_pcn == pcn0 && mem_req_o_bits_idx == 4'd11 && !llc_req_i_ready)
        lat++;
    end
    chk("bp_stable_cycles", lat, 64'd10);
    chk("bp_pcn", {22'd0, pcn0}, 64'h1810);
    mem_accept();

    // Memory response pending alongside a fault: memory goes first.
    mem_resp_i_valid = 1'b1; mem_resp_i_bits_idx = 4'd7; mem_resp_i_bits_err = 1'b0;
    send_req(1'b0, 58'h3456, 4'd9, '0);
    tick();
    chk("prio_first_idx", {60'd0, llc_resp_o_bits_idx}, 64'd7);
    chk("prio_first_err", {63'd0, llc_resp_o_bits_err}, 64'd0);
    llc_resp_o_ready = 1'b1;
    #1;
    chk("prio_mem_ready", {63'd0, mem_resp_i_ready}, 64'd1);
    tick();
    mem_resp_i_valid = 1'b0; llc_resp_o_ready = 1'b0;
    #1;
    chk("prio_fault_valid", {63'd0, llc_resp_o_valid}, 64'd1);
    chk("prio_fault_idx", {60'd0, llc_resp_o_bits_idx}, 64'd9);
    chk("prio_fault_err", {63'd0, llc_resp_o_bits_err}, 64'd1);
    resp_accept();
    ctl_acc(1'b1, 64'h90, 64'd0, s, rd);
    chk("fault_cnt_3", rd, 64'd3);

    // Read-only write is ignored but selected; unmapped access returns sel=0.
    ctl_acc(1'b0, 64'h90, 64'h0, s, rd);
    chk("ro_write_sel", {63'd0, s}, 64'd1);
    ctl_acc(1'b1, 64'h90, 64'd0, s, rd);
    chk("ro_write_ignored", rd, 64'd3);
    ctl_acc(1'b1, 64'h200, 64'd0, s, rd);
    chk("unmapped_sel", {63'd0, s}, 64'd0);
    chk("unmapped_data", rd, 64'd0);

    // Segment register readback.
    for (int i = 0; i < 4; i++) begin
      for (int f = 0; f < 4; f++) begin
        ctl_wr(64'h10 + 64'(32 * i + 8 * f), 64'hA5A5_A5A5_A5A5_A5A5);
        ctl_acc(1'b1, 64'h10 + 64'(32 * i + 8 * f), 64'd0, s, rd);
        chk("seg_readback", rd, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("seg_readback_sel", {63'd0, s}, 64'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
